// File: rtl/ru_writeback_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register-unit write-back sequencer.
//   wb_src_e           : write-back mux source encoding (ALU / MEM / ADDER)
//   wb_state_e         : sequencer FSM states
//   WB_TIMEOUT_DEFAULT : default load-wait budget in cycles
//   wb_eff_src()       : maps the reserved source code onto ALU
// ---------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        ALU   = 2'b00,
        MEM   = 2'b01,
        ADDER = 2'b10
    } wb_src_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        COMMIT    = 2'b10
    } wb_state_e;

    localparam int WB_TIMEOUT_DEFAULT = 16;

    // The reserved code 2'b11 has no mux input of its own; it falls back to ALU.
    function automatic logic [1:0] wb_eff_src(input logic [1:0] src);
        logic [1:0] eff_s;
        if (src == 2'b11) begin
            eff_s = ALU;
        end else begin
            eff_s = src;
        end
        return eff_s;
    endfunction

endpackage

// File: rtl/ru_writeback_sequencer_timeout_ctr.sv
// ---------------------------------------------------------------------------
// wb_timeout_ctr
// Counts cycles spent waiting on the data memory.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return the count to zero (takes priority over en)
//   en       : advance the count by one
//   expired  : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module wb_timeout_ctr #(
    parameter  int TIMEOUT = 16,
    localparam int W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_r;

    // Wait-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= W'(1'b0);
        end else if (en) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == W'(TIMEOUT - 1));

endmodule

// File: rtl/ru_writeback_sequencer.sv
// ---------------------------------------------------------------------------
// ru_writeback_sequencer
// Drives the register-unit write port and the write-back mux select.
// ALU / ADDER results commit in the issuing cycle; loads stall the PC until
// the data memory answers, then commit the captured data through the mux
// memory input. A load that is never answered is dropped and flagged.
//   instr_valid, ru_wr, ru_data_wr_src, rd : control-unit write request
//   dm_ready, dm_rdata                     : data-memory read response
//   dm_req                                 : load request to data memory
//   ru_wr_en, ru_rd_addr, ru_src_sel       : register-unit write port / mux
//   load_data                              : captured load data
//   pc_stall, busy, err                    : stall, activity, sticky timeout
// ---------------------------------------------------------------------------
module ru_writeback_sequencer
    import wb_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        ru_wr,
    input  logic [1:0]  ru_data_wr_src,
    input  logic [4:0]  rd,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        ru_wr_en,
    output logic [4:0]  ru_rd_addr,
    output logic [1:0]  ru_src_sel,
    output logic [31:0] load_data,
    output logic        pc_stall,
    output logic        busy,
    output logic        err
);

    wb_state_e   state_r, state_s;
    logic [4:0]  rd_q_r;
    logic [31:0] load_data_r;
    logic        err_r;

    logic        latch_rd_s;
    logic        capture_s;
    logic        err_set_s;
    logic        ctr_clr_s;
    logic        ctr_en_s;
    logic        expired_s;

    logic        dm_req_s;
    logic        wr_en_s;
    logic [4:0]  rd_addr_s;
    logic [1:0]  src_sel_s;
    logic        stall_s;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr_s),
        .en      (ctr_en_s),
        .expired (expired_s)
    );

    // Next-state and output decode; IDLE is Mealy, the wait states are Moore.
    always_comb begin
        state_s    = state_r;
        latch_rd_s = 1'b0;
        capture_s  = 1'b0;
        err_set_s  = 1'b0;
        ctr_clr_s  = 1'b1;
        ctr_en_s   = 1'b0;
        dm_req_s   = 1'b0;
        wr_en_s    = 1'b0;
        rd_addr_s  = 5'd0;
        src_sel_s  = ALU;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (instr_valid && ru_wr) begin
                    rd_addr_s = rd;
                    if (ru_data_wr_src == MEM) begin
                        // dm_ready is not looked at here: the request is only
                        // being raised in this cycle.
                        src_sel_s  = MEM;
                        dm_req_s   = 1'b1;
                        stall_s    = 1'b1;
                        latch_rd_s = 1'b1;
                        state_s    = LOAD_WAIT;
                    end else begin
                        src_sel_s = wb_eff_src(ru_data_wr_src);
                        wr_en_s   = (rd != 5'd0);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                dm_req_s  = 1'b1;
                stall_s   = 1'b1;
                src_sel_s = MEM;
                rd_addr_s = rd_q_r;
                // dm_ready is checked before the timeout so a response on the
                // last allowed cycle still commits.
                if (dm_ready) begin
                    capture_s = 1'b1;
                    state_s   = COMMIT;
                end else if (expired_s) begin
                    err_set_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    ctr_clr_s = 1'b0;
                    ctr_en_s  = 1'b1;
                end
            end
            COMMIT: begin
                wr_en_s   = (rd_q_r != 5'd0);
                src_sel_s = MEM;
                rd_addr_s = rd_q_r;
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, destination latch, load data capture and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rd_q_r      <= 5'd0;
            load_data_r <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            if (latch_rd_s) begin
                rd_q_r <= rd;
            end else begin
                rd_q_r <= rd_q_r;
            end
            if (capture_s) begin
                load_data_r <= dm_rdata;
            end else begin
                load_data_r <= load_data_r;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign dm_req     = dm_req_s;
    assign ru_wr_en   = wr_en_s;
    assign ru_rd_addr = rd_addr_s;
    assign ru_src_sel = src_sel_s;
    assign pc_stall   = stall_s;
    assign busy       = (state_r != IDLE);
    assign load_data  = load_data_r;
    assign err        = err_r;

endmodule
